multicycle_control_fsm: RTL and testbench

//  Main sequencer for the multi-cycle RV32I core. Walks each instruction through

---
 rtl/multicycle_control_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and strobes.
module multicycle_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_en_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic [2:0] imm_src_o,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR_ADR = 4'd11,
        S_EXEC_U   = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    state_t     state_r;
    logic       illegal_r;

    logic       mem_req_s;
    logic       mem_we_s;
    logic       adr_src_s;
    logic       ir_write_s;
    logic       pc_en_s;
    logic       reg_write_s;
    logic [1:0] src_a_s;
    logic [1:0] src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] result_src_s;
    logic [2:0] imm_src_s;

    // Immediate format implied by the opcode; formats without an immediate fall back to I.
    function automatic logic [2:0] imm_decode(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b1101111: imm = 3'b011;
            7'b0110111,
            7'b0010111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        return imm;
    endfunction

    // Sequencer state and sticky illegal-opcode flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= state_t'(RESET_STATE);
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (mem_ready_i) begin
                        state_r <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op_i)
                        7'b0000011,
                        7'b0100011: state_r <= S_MEMADR;
                        7'b0110011: state_r <= S_EXEC_R;
                        7'b0010011: state_r <= S_EXEC_I;
                        7'b1100011: state_r <= S_BRANCH;
                        7'b1101111: state_r <= S_JAL;
                        7'b1100111: state_r <= S_JALR_ADR;
                        7'b0110111,
                        7'b0010111: state_r <= S_EXEC_U;
                        default: begin
                            state_r   <= S_TRAP;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   state_r <= op_i[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: begin
                    if (mem_ready_i) begin
                        state_r <= S_MEMWB;
                    end
                end
                S_MEMWB:    state_r <= S_FETCH;
                S_MEMWRITE: begin
                    if (mem_ready_i) begin
                        state_r <= S_FETCH;
                    end
                end
                S_EXEC_R,
                S_EXEC_I,
                S_EXEC_U:   state_r <= S_ALU_WB;
                S_ALU_WB:   state_r <= S_FETCH;
                S_BRANCH:   state_r <= S_FETCH;
                S_JALR_ADR: state_r <= S_JAL;
                S_JAL:      state_r <= S_ALU_WB;
                S_TRAP:     illegal_r <= 1'b1;
                default: begin
                    // Unused encodings are treated as a fault and parked in TRAP.
                    state_r   <= S_TRAP;
                    illegal_r <= 1'b1;
                end
            endcase
        end
    end

    // Moore decode of the datapath controls; FETCH and BRANCH strobes are input-qualified.
    always_comb begin
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_en_s      = 1'b0;
        reg_write_s  = 1'b0;
        src_a_s      = 2'b00;
        src_b_s      = 2'b00;
        alu_op_s     = 2'b00;
        result_src_s = 2'b00;
        imm_src_s    = imm_decode(op_i);
        case (state_r)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                src_b_s      = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ready_i;
                pc_en_s      = mem_ready_i;
            end
            S_DECODE: begin
                src_a_s = 2'b01;
                src_b_s = 2'b01;
            end
            S_MEMADR: begin
                src_a_s = 2'b10;
                src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                adr_src_s = 1'b1;
            end
            S_EXEC_R: begin
                src_a_s  = 2'b10;
                alu_op_s = 2'b10;
            end
            S_EXEC_I: begin
                src_a_s  = 2'b10;
                src_b_s  = 2'b01;
                alu_op_s = 2'b10;
            end
            S_EXEC_U: begin
                // LUI adds the immediate to zero, AUIPC to the old PC.
                src_a_s = op_i[5] ? 2'b11 : 2'b01;
                src_b_s = 2'b01;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                src_a_s  = 2'b10;
                alu_op_s = 2'b01;
                pc_en_s  = zero_i ^ funct3_i[0];
            end
            S_JALR_ADR: begin
                src_a_s = 2'b10;
                src_b_s = 2'b01;
            end
            S_JAL: begin
                src_a_s = 2'b01;
                src_b_s = 2'b10;
                pc_en_s = 1'b1;
            end
            S_TRAP: begin
                mem_req_s = 1'b0;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Force every control to zero while reset is held, so an in-flight request drops at once.
    always_comb begin
        if (rst_i) begin
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            adr_src_o    = 1'b0;
            ir_write_o   = 1'b0;
            pc_en_o      = 1'b0;
            reg_write_o  = 1'b0;
            alu_src_a_o  = 2'b00;
            alu_src_b_o  = 2'b00;
            alu_op_o     = 2'b00;
            result_src_o = 2'b00;
            imm_src_o    = 3'b000;
        end else begin
            mem_req_o    = mem_req_s;
            mem_we_o     = mem_we_s;
            adr_src_o    = adr_src_s;
            ir_write_o   = ir_write_s;
            pc_en_o      = pc_en_s;
            reg_write_o  = reg_write_s;
            alu_src_a_o  = src_a_s;
            alu_src_b_o  = src_b_s;
            alu_op_o     = alu_op_s;
            result_src_o = result_src_s;
            imm_src_o    = imm_src_s;
        end
    end

    assign state_o   = state_r;
    assign illegal_o = illegal_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: instruction-level path model plus
// per-state control table, compared every cycle, with literal spot checks.
module tb_multicycle_control_fsm;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [6:0] op_i;
    logic [2:0] funct3_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_en_o, reg_write_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
    logic [2:0] imm_src_o;
    logic [3:0] state_o;
    logic       illegal_o;

    int passes = 0;
    int total  = 0;
    int exp_state = 0;
    bit exp_valid = 1'b0;
    int mreq_n, data_n, memwb_n, pcen_n, regw_n;

    multicycle_control_fsm dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .adr_src_o(adr_src_o), .ir_write_o(ir_write_o),
        .pc_en_o(pc_en_o), .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .result_src_o(result_src_o),
        .imm_src_o(imm_src_o), .state_o(state_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b1101111:             return 3'd3;
            7'b0110111, 7'b0010111: return 3'd4;
            default:                return 3'd0;
        endcase
    endfunction

    // Control table: {mem_req,we,adr,irw,pcen,regw,a,b,aluop,res,imm,illegal,state}
    function automatic logic [21:0] exp_out(input int s, input logic [6:0] op,
                                            input logic f3_0, input logic z, input logic rdy);
        logic req = 0, we = 0, adr = 0, irw = 0, pce = 0, rw = 0;
        logic [1:0] a = 0, b = 0, ao = 0, res = 0;
        if (s == 0)  begin req = 1; b = 2; res = 2; irw = rdy; pce = rdy; end
        if (s == 1)  begin a = 1; b = 1; end
        if (s == 2)  begin a = 2; b = 1; end
        if (s == 3)  begin req = 1; adr = 1; end
        if (s == 4)  begin res = 1; rw = 1; end
        if (s == 5)  begin req = 1; we = 1; adr = 1; end
        if (s == 6)  begin a = 2; ao = 2; end
        if (s == 7)  begin a = 2; b = 1; ao = 2; end
        if (s == 8)  begin rw = 1; end
        if (s == 9)  begin a = 2; ao = 1; pce = z ^ f3_0; end
        if (s == 10) begin a = 1; b = 2; pce = 1; end
        if (s == 11) begin a = 2; b = 1; end
        if (s == 12) begin a = op[5] ? 2'd3 : 2'd1; b = 1; end
        return {req, we, adr, irw, pce, rw, a, b, ao, res, imm_of(op), (s == 15), 4'(s)};
    endfunction

    // Single compare point, half a cycle after the active edge.
    always @(negedge clk_i) begin
        logic [21:0] act;
        act = {mem_req_o, mem_we_o, adr_src_o, ir_write_o, pc_en_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, imm_src_o, illegal_o, state_o};
        if (rst_i) check("reset_outputs", 32'(act), 32'd0);
        else if (exp_valid)
            check($sformatf("cycle_outputs_s%0d", exp_state), 32'(act),
                  32'(exp_out(exp_state, op_i, funct3_i[0], zero_i, mem_ready_i)));
        if (mem_req_o) mreq_n++;
        if (mem_req_o && adr_src_o) data_n++;
        if (state_o == 4'd4) memwb_n++;
        if (pc_en_o) pcen_n++;
        if (reg_write_o) regw_n++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_exp(input int s, input logic rdy);
        mem_ready_i = rdy;
        exp_state   = s;
        exp_valid   = 1'b1;
    endtask

    task automatic clr_counts();
        mreq_n = 0; data_n = 0; memwb_n = 0; pcen_n = 0; regw_n = 0;
    endtask

    // Visit list of an instruction, with fw fetch waits and mw data-memory waits.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fw, input int mw, input logic idle_rdy);
        int   st[$];
        logic rd[$];
        op_i = op; funct3_i = f3; zero_i = z;
        for (int i = 0; i < fw; i++) begin st.push_back(0); rd.push_back(1'b0); end
        st.push_back(0); rd.push_back(1'b1);
        st.push_back(1); rd.push_back(idle_rdy);
        case (op)
            7'b0110011: begin st.push_back(6); st.push_back(8); end
            7'b0010011: begin st.push_back(7); st.push_back(8); end
            7'b0110111, 7'b0010111: begin st.push_back(12); st.push_back(8); end
            7'b0000011, 7'b0100011: begin
                st.push_back(2); rd.push_back(idle_rdy);
                for (int i = 0; i < mw; i++) begin st.push_back(op[5] ? 5 : 3); rd.push_back(1'b0); end
                st.push_back(op[5] ? 5 : 3); rd.push_back(1'b1);
                if (!op[5]) st.push_back(4);
            end
            7'b1100011: st.push_back(9);
            7'b1101111: begin st.push_back(10); st.push_back(8); end
            7'b1100111: begin st.push_back(11); st.push_back(10); st.push_back(8); end
            default: for (int i = 0; i < 20; i++) st.push_back(15);
        endcase
        while (rd.size() < st.size()) rd.push_back(idle_rdy);
        for (int i = 0; i < st.size(); i++) begin
            set_exp(st[i], rd[i]);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; op_i = 7'd0; funct3_i = 3'd0; zero_i = 1'b0; mem_ready_i = 1'b0;
        clr_counts();
        tick(); tick();
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_mem_req", 32'(mem_req_o), 32'd0);
        rst_i = 1'b0;

        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, 1'b1);   // ADD, ready tied high
        run_instr(7'b0010011, 3'd0, 1'b0, 2, 0, 1'b0);   // ADDI, fetch waits
        run_instr(7'b0110111, 3'd0, 1'b0, 0, 0, 1'b0);   // LUI
        run_instr(7'b0010111, 3'd0, 1'b0, 0, 0, 1'b1);   // AUIPC

        clr_counts();
        run_instr(7'b0000011, 3'd2, 1'b0, 0, 3, 1'b0);   // LW, 3 wait cycles
        check("lw_data_req_cycles", 32'(data_n), 32'd4);
        check("lw_memwb_cycles", 32'(memwb_n), 32'd1);
        check("lw_back_to_fetch", 32'(state_o), 32'd0);

        run_instr(7'b0100011, 3'd2, 1'b0, 0, 1, 1'b1);   // SW, 1 wait cycle
        run_instr(7'b1100011, 3'd0, 1'b1, 0, 0, 1'b1);   // BEQ taken

        // BNE with zero set then clear
        op_i = 7'b1100011; funct3_i = 3'b001; zero_i = 1'b1;
        set_exp(0, 1'b1); tick(); set_exp(1, 1'b1); tick(); set_exp(9, 1'b1);
        #2 check("bne_zero1_pc_en", 32'(pc_en_o), 32'd0);
        tick();
        check("bne_zero1_fetch", 32'(state_o), 32'd0);
        zero_i = 1'b0;
        set_exp(0, 1'b1); tick(); set_exp(1, 1'b1); tick(); set_exp(9, 1'b1);
        #2 check("bne_zero0_pc_en", 32'(pc_en_o), 32'd1);
        tick();
        check("bne_zero0_fetch", 32'(state_o), 32'd0);

        run_instr(7'b1101111, 3'd0, 1'b0, 0, 0, 1'b1);   // JAL
        clr_counts();
        run_instr(7'b1100111, 3'd0, 1'b0, 0, 0, 1'b1);   // JALR
        check("jalr_pc_en_cycles", 32'(pcen_n), 32'd2);
        check("jalr_reg_write_cycles", 32'(regw_n), 32'd1);

        // Reset while a load waits in MEMREAD
        op_i = 7'b0000011; funct3_i = 3'd2;
        set_exp(0, 1'b1); tick(); set_exp(1, 1'b0); tick(); set_exp(2, 1'b0); tick();
        set_exp(3, 1'b0); tick();
        check("memread_req_before_reset", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        #1 check("memread_req_in_reset", 32'(mem_req_o), 32'd0);
        check("memread_state_in_reset", 32'(state_o), 32'd0);
        tick(); tick();
        rst_i = 1'b0;
        run_instr(7'b0110011, 3'd0, 1'b0, 0, 0, 1'b1);

        // Illegal opcode parks in TRAP until reset
        clr_counts();
        run_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 1'b1);
        check("trap_mem_req_cycles", 32'(mreq_n), 32'd1);
        check("trap_illegal", 32'(illegal_o), 32'd1);
        op_i = 7'b0110011;
        set_exp(15, 1'b1); tick(); set_exp(15, 1'b1); tick();
        check("trap_sticky_state", 32'(state_o), 32'd15);
        rst_i = 1'b1;
        #1 check("trap_illegal_cleared", 32'(illegal_o), 32'd0);
        tick();
        rst_i = 1'b0;
        run_instr(7'b0110011, 3'd0, 1'b0, 1, 0, 1'b1);
        exp_valid = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
